// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared definitions for the convolution sequencing controller:
//                FSM state encoding plus the default weight-load length and
//                drain idle timeout used by conv_seq_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } conv_state_t;

    // Cycles wr_weight_en is held while the datapath captures the kernel
    localparam int c_WLOAD_CYCLES  = 2;
    // Idle cycles tolerated in DRAIN before the job is declared timed out
    localparam int c_DRAIN_TIMEOUT = 200;
    // Width of the drain idle counter (DRAIN_TIMEOUT must fit in it)
    localparam int c_DRAIN_CNT_W   = 8;

endpackage
`default_nettype wire

// File: rtl/conv_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : conv_beat_counter
//  Description : Saturating beat counter with synchronous clear.
//                clear has priority over enable; the count sticks at all-ones.
//  Ports       : clk, rstn     - clock, asynchronous active-low reset
//                i_clr         - synchronous clear to zero
//                i_en          - count one beat
//                o_count       - current count (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_beat_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_MAX = '1;

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : conv_seq_ctrl
//  Description : Job sequencer for a convolution datapath. On start it loads
//                the kernel weights, forwards N host windows to the datapath
//                with zero latency, then waits for N output beats (with an
//                idle timeout) before pulsing done.
//  Ports       : clk, rstn                 - clock, async active-low reset
//                start, abort              - job request / cancel
//                cfg_weights, cfg_num_windows - job configuration (latched)
//                s_axis_*                  - host window stream (slave)
//                weight_array, wr_weight_en - weight load to datapath
//                fifoIn_axis_*             - window stream to datapath
//                fifoOut_axim_tvalid/tready - monitored datapath output
//                is_last                   - final window beat marker
//                busy, done, timeout_err   - job status
//                out_count                 - output beats seen this job
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int WEIGHT_WIDTH  = 1,
    parameter int DATA_WIDTH    = 8,
    parameter int KERNEL_SIZE   = 2,
    parameter int ADDRESS_WIDTH = 5,
    parameter int WLOAD_CYCLES  = c_WLOAD_CYCLES,
    parameter int DRAIN_TIMEOUT = c_DRAIN_TIMEOUT
) (
    input  logic                                          clk,
    input  logic                                          rstn,
    input  logic                                          start,
    input  logic                                          abort,
    input  logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] cfg_weights,
    input  logic [ADDRESS_WIDTH-1:0]                      cfg_num_windows,
    input  logic                                          s_axis_tvalid,
    input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0]   s_axis_tdata,
    output logic                                          s_axis_tready,
    output logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] weight_array,
    output logic                                          wr_weight_en,
    output logic                                          fifoIn_axis_tvalid,
    output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0]   fifoIn_axis_tdata,
    input  logic                                          fifoIn_axis_tready,
    input  logic                                          fifoOut_axim_tvalid,
    input  logic                                          fifoOut_axim_tready,
    output logic                                          is_last,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          timeout_err,
    output logic [ADDRESS_WIDTH-1:0]                      out_count
);

    localparam int c_WVEC_W = WEIGHT_WIDTH * KERNEL_SIZE * KERNEL_SIZE;
    localparam int c_WL_W   = (WLOAD_CYCLES > 1) ? $clog2(WLOAD_CYCLES) : 1;
    localparam logic [c_WL_W-1:0]        c_WL_LAST    = c_WL_W'(WLOAD_CYCLES - 1);
    localparam logic [c_DRAIN_CNT_W-1:0] c_DRAIN_LAST = c_DRAIN_CNT_W'(DRAIN_TIMEOUT - 1);

    conv_state_t                r_state;
    logic [c_WVEC_W-1:0]        r_weights;
    logic [ADDRESS_WIDTH-1:0]   r_num_windows;
    logic [c_WL_W-1:0]          r_wload_cnt;
    logic [c_DRAIN_CNT_W-1:0]   r_drain_cnt;
    logic                       r_timeout_err;

    logic                       w_streaming;
    logic                       w_start_job;
    logic                       w_in_beat;
    logic                       w_out_beat;
    logic [ADDRESS_WIDTH-1:0]   w_in_cnt;
    logic [ADDRESS_WIDTH-1:0]   w_out_cnt;

    // Stream gate: handshakes only pass while streaming. Data is a plain
    // wire-through since it is only meaningful alongside tvalid.
    assign w_streaming        = (r_state == ST_STREAM);
    assign fifoIn_axis_tvalid = w_streaming & s_axis_tvalid;
    assign s_axis_tready      = w_streaming & fifoIn_axis_tready;
    assign fifoIn_axis_tdata  = s_axis_tdata;

    // Abort also suppresses a start seen in the same cycle
    assign w_start_job = (r_state == ST_IDLE) & start & ~abort;
    assign w_in_beat   = fifoIn_axis_tvalid & fifoIn_axis_tready;
    assign w_out_beat  = fifoOut_axim_tvalid & fifoOut_axim_tready &
                         ((r_state == ST_STREAM) | (r_state == ST_DRAIN));

    // N is at least 1 whenever STREAM is reached, so N-1 never wraps here
    assign is_last = fifoIn_axis_tvalid & (w_in_cnt == (r_num_windows - 1'b1));

    conv_beat_counter #(.WIDTH(ADDRESS_WIDTH)) u_in_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .i_clr   (w_start_job),
        .i_en    (w_in_beat),
        .o_count (w_in_cnt)
    );

    conv_beat_counter #(.WIDTH(ADDRESS_WIDTH)) u_out_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .i_clr   (w_start_job),
        .i_en    (w_out_beat),
        .o_count (w_out_cnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_weights     <= '0;
            r_num_windows <= '0;
            r_wload_cnt   <= '0;
            r_drain_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else if (abort) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_weights     <= cfg_weights;
                        r_num_windows <= cfg_num_windows;
                        r_wload_cnt   <= '0;
                        r_drain_cnt   <= '0;
                        r_timeout_err <= 1'b0;
                        r_state       <= ST_LOAD_W;
                    end
                end
                ST_LOAD_W: begin
                    if (r_wload_cnt == c_WL_LAST) begin
                        r_state <= (r_num_windows == '0) ? ST_DONE : ST_STREAM;
                    end else begin
                        r_wload_cnt <= r_wload_cnt + 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (w_in_beat && is_last) begin
                        r_drain_cnt <= '0;
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Output count may already be complete on entry, in which
                    // case DRAIN lasts a single cycle.
                    if (w_out_cnt == r_num_windows) begin
                        r_state <= ST_DONE;
                    end else if (w_out_beat) begin
                        r_drain_cnt <= '0;
                    end else if (r_drain_cnt == c_DRAIN_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign weight_array = r_weights;
    assign wr_weight_en = (r_state == ST_LOAD_W);
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);
    assign timeout_err  = r_timeout_err;
    assign out_count    = w_out_cnt;

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_seq_ctrl
//  Description : Directed self-checking bench for conv_seq_ctrl with the
//                default configuration (K=2, 1-bit weights, 8-bit pixels).
//                Inputs are driven just after the falling edge and outputs
//                sampled a step later, well away from the rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_seq_ctrl;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        abort;
    logic [3:0]  cfg_weights;
    logic [4:0]  cfg_num_windows;
    logic        s_axis_tvalid;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tready;
    logic [3:0]  weight_array;
    logic        wr_weight_en;
    logic        fifoIn_axis_tvalid;
    logic [31:0] fifoIn_axis_tdata;
    logic        fifoIn_axis_tready;
    logic        fifoOut_axim_tvalid;
    logic        fifoOut_axim_tready;
    logic        is_last;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [4:0]  out_count;

    int n_checks;
    int n_fail;

    conv_seq_ctrl dut (
        .clk                 (clk),
        .rstn                (rstn),
        .start               (start),
        .abort               (abort),
        .cfg_weights         (cfg_weights),
        .cfg_num_windows     (cfg_num_windows),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tready       (s_axis_tready),
        .weight_array        (weight_array),
        .wr_weight_en        (wr_weight_en),
        .fifoIn_axis_tvalid  (fifoIn_axis_tvalid),
        .fifoIn_axis_tdata   (fifoIn_axis_tdata),
        .fifoIn_axis_tready  (fifoIn_axis_tready),
        .fifoOut_axim_tvalid (fifoOut_axim_tvalid),
        .fifoOut_axim_tready (fifoOut_axim_tready),
        .is_last             (is_last),
        .busy                (busy),
        .done                (done),
        .timeout_err         (timeout_err),
        .out_count           (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance to just after the next falling edge
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] w, input logic [4:0] n);
        start           = 1'b1;
        cfg_weights     = w;
        cfg_num_windows = n;
        cyc();
        start           = 1'b0;
        cfg_weights     = 4'h0;
        cfg_num_windows = 5'd0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; abort = 1'b0; cfg_weights = 4'h0; cfg_num_windows = 5'd0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'h0; fifoIn_axis_tready = 1'b1;
        fifoOut_axim_tvalid = 1'b0; fifoOut_axim_tready = 1'b0;
        #23;
        n_checks++;
        if ({wr_weight_en, weight_array, is_last, busy, done, timeout_err, out_count,
             fifoIn_axis_tvalid, s_axis_tready} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0000", {wr_weight_en, weight_array, is_last, busy,
                     done, timeout_err, out_count, fifoIn_axis_tvalid, s_axis_tready});
        end
        cyc();
        rstn = 1'b1; s_axis_tvalid = 1'b0; fifoIn_axis_tready = 1'b0;
        cyc();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy=%b required 0", busy); end
    endtask

    task automatic test_basic();
        int nd;
        do_start(4'hf, 5'd3);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (wr_weight_en !== 1'b1) begin n_fail++; $display("FAIL basic_wen cyc%0d: got %b required 1", i, wr_weight_en); end
            n_checks++;
            if (weight_array !== 4'hf) begin n_fail++; $display("FAIL basic_weights: got %h required f", weight_array); end
            cyc();
        end
        fifoIn_axis_tready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {16'h0, 8'd1, 8'(5 - b)};
            #1;
            n_checks++;
            if (wr_weight_en !== 1'b0) begin n_fail++; $display("FAIL basic_wen_off: got %b required 0", wr_weight_en); end
            n_checks++;
            if (fifoIn_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b1) begin
                n_fail++; $display("FAIL basic_pass beat%0d: tvalid=%b tready=%b required 1 1", b, fifoIn_axis_tvalid, s_axis_tready);
            end
            n_checks++;
            if (fifoIn_axis_tdata !== {16'h0, 8'd1, 8'(5 - b)}) begin
                n_fail++; $display("FAIL basic_data beat%0d: got %h required %h", b, fifoIn_axis_tdata, {16'h0, 8'd1, 8'(5 - b)});
            end
            n_checks++;
            if (is_last !== (b == 2)) begin n_fail++; $display("FAIL basic_is_last beat%0d: got %b required %b", b, is_last, (b == 2)); end
            cyc();
        end
        s_axis_tvalid = 1'b0; fifoIn_axis_tready = 1'b0;
        fifoOut_axim_tvalid = 1'b1; fifoOut_axim_tready = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        fifoOut_axim_tvalid = 1'b0; fifoOut_axim_tready = 1'b0;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (done === 1'b1) nd++;
            cyc();
        end
        n_checks++;
        if (nd !== 1) begin n_fail++; $display("FAIL basic_done_cycles: got %0d required 1", nd); end
        n_checks++;
        if (out_count !== 5'd3) begin n_fail++; $display("FAIL basic_out_count: got %0d required 3", out_count); end
        n_checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL basic_end_status: busy=%b timeout=%b required 0 0", busy, timeout_err);
        end
    endtask

    task automatic test_toggle_ready();
        int k;
        int i;
        logic [31:0] exp_data;
        do_start(4'ha, 5'd4);
        cyc(); cyc();
        k = 0; i = 0;
        while (k < 4 && i < 20) begin
            fifoIn_axis_tready  = (i % 2 == 0);
            s_axis_tvalid       = 1'b1;
            exp_data            = 32'hA000 + 32'(k);
            s_axis_tdata        = exp_data;
            fifoOut_axim_tvalid = (i < 4);
            fifoOut_axim_tready = (i < 4);
            #1;
            n_checks++;
            if (fifoIn_axis_tdata !== exp_data || fifoIn_axis_tvalid !== 1'b1) begin
                n_fail++; $display("FAIL toggle_data cyc%0d: got %h/%b required %h/1", i, fifoIn_axis_tdata, fifoIn_axis_tvalid, exp_data);
            end
            n_checks++;
            if (s_axis_tready !== (i % 2 == 0)) begin n_fail++; $display("FAIL toggle_ready cyc%0d: got %b required %b", i, s_axis_tready, (i % 2 == 0)); end
            n_checks++;
            if (is_last !== (k == 3)) begin n_fail++; $display("FAIL toggle_is_last cyc%0d: got %b required %b", i, is_last, (k == 3)); end
            if (i % 2 == 0) k++;
            cyc();
            i++;
        end
        n_checks++;
        if (k !== 4) begin n_fail++; $display("FAIL toggle_beats: got %0d required 4", k); end
        fifoIn_axis_tready = 1'b1; fifoOut_axim_tvalid = 1'b0; fifoOut_axim_tready = 1'b0;
        #1;
        n_checks++;
        if (fifoIn_axis_tvalid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL toggle_drain: tvalid=%b busy=%b done=%b required 0 1 0", fifoIn_axis_tvalid, busy, done);
        end
        cyc();
        n_checks++;
        if (done !== 1'b1 || out_count !== 5'd4) begin
            n_fail++; $display("FAIL toggle_done: done=%b out_count=%0d required 1 4", done, out_count);
        end
        cyc();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL toggle_idle: done=%b busy=%b required 0 0", done, busy); end
        s_axis_tvalid = 1'b0; fifoIn_axis_tready = 1'b0;
    endtask

    task automatic test_timeout();
        int dc;
        int got;
        int i;
        do_start(4'h3, 5'd2);
        cyc(); cyc();
        fifoIn_axis_tready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            s_axis_tvalid = 1'b1;
            #1;
            n_checks++;
            if (is_last !== (b == 1)) begin n_fail++; $display("FAIL timeout_is_last beat%0d: got %b required %b", b, is_last, (b == 1)); end
            cyc();
        end
        s_axis_tvalid = 1'b0; fifoIn_axis_tready = 1'b0;
        dc = 0; got = 0; i = 0;
        while (got == 0 && i < 300) begin
            #1;
            if (done === 1'b1) got = 1;
            else begin
                if (busy === 1'b1) dc++;
                cyc();
            end
            i++;
        end
        n_checks++;
        if (got !== 1) begin n_fail++; $display("FAIL timeout_done_seen: got %0d required 1", got); end
        n_checks++;
        if (dc !== 200) begin n_fail++; $display("FAIL timeout_drain_len: got %0d required 200", dc); end
        n_checks++;
        if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_set: got %b required 1", timeout_err); end
        cyc();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_hold: done=%b busy=%b err=%b required 0 0 1", done, busy, timeout_err);
        end
    endtask

    task automatic test_zero_windows();
        int nw, nv, nd;
        s_axis_tvalid = 1'b1; fifoIn_axis_tready = 1'b1;
        do_start(4'h5, 5'd0);
        nw = 0; nv = 0; nd = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i == 0) begin
                n_checks++;
                if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL zero_err_cleared: got %b required 0", timeout_err); end
            end
            if (wr_weight_en === 1'b1) nw++;
            if (fifoIn_axis_tvalid === 1'b1) nv++;
            if (done === 1'b1) nd++;
            cyc();
        end
        n_checks++;
        if (nw !== 2) begin n_fail++; $display("FAIL zero_wen_cycles: got %0d required 2", nw); end
        n_checks++;
        if (nv !== 0) begin n_fail++; $display("FAIL zero_tvalid: got %0d required 0", nv); end
        n_checks++;
        if (nd !== 1) begin n_fail++; $display("FAIL zero_done: got %0d required 1", nd); end
        n_checks++;
        if (weight_array !== 4'h5) begin n_fail++; $display("FAIL zero_weight_hold: got %h required 5", weight_array); end
        s_axis_tvalid = 1'b0; fifoIn_axis_tready = 1'b0;
    endtask

    task automatic test_abort_and_reset();
        int nd;
        do_start(4'hc, 5'd3);
        cyc(); cyc();
        fifoIn_axis_tready = 1'b1; s_axis_tvalid = 1'b1;
        #1;
        n_checks++;
        if (fifoIn_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL abort_stream: got %b required 1", fifoIn_axis_tvalid); end
        cyc();
        s_axis_tvalid = 1'b0; abort = 1'b1;
        cyc();
        abort = 1'b0; s_axis_tvalid = 1'b1;
        #1;
        n_checks++;
        if ({busy, fifoIn_axis_tvalid, s_axis_tready, wr_weight_en} !== 4'b0) begin
            n_fail++; $display("FAIL abort_idle: busy/tvalid/tready/wen=%b required 0000", {busy, fifoIn_axis_tvalid, s_axis_tready, wr_weight_en});
        end
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (done === 1'b1) nd++;
            cyc();
        end
        n_checks++;
        if (nd !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d required 0", nd); end
        s_axis_tvalid = 1'b0;
        start = 1'b1; abort = 1'b1; cfg_num_windows = 5'd1;
        cyc();
        start = 1'b0; abort = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_beats_start: busy=%b required 0", busy); end
        do_start(4'h9, 5'd3);
        cyc(); cyc();
        s_axis_tvalid = 1'b1; fifoOut_axim_tvalid = 1'b1; fifoOut_axim_tready = 1'b1;
        cyc();
        #1;
        n_checks++;
        if (busy !== 1'b1 || out_count !== 5'd1) begin
            n_fail++; $display("FAIL rst_pre: busy=%b out_count=%0d required 1 1", busy, out_count);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({wr_weight_en, weight_array, is_last, busy, done, timeout_err, out_count,
             fifoIn_axis_tvalid, s_axis_tready} !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_mid_stream: got %h required 0000", {wr_weight_en, weight_array, is_last, busy,
                     done, timeout_err, out_count, fifoIn_axis_tvalid, s_axis_tready});
        end
        cyc();
        rstn = 1'b1; s_axis_tvalid = 1'b0; fifoOut_axim_tvalid = 1'b0; fifoOut_axim_tready = 1'b0;
        fifoIn_axis_tready = 1'b0;
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (done === 1'b1 || busy === 1'b1) nd++;
            cyc();
        end
        n_checks++;
        if (nd !== 0) begin n_fail++; $display("FAIL rst_no_done: active cycles %0d required 0", nd); end
    endtask

    task automatic test_start_while_busy();
        int nd;
        do_start(4'h6, 5'd2);
        start = 1'b1; cfg_weights = 4'h1; cfg_num_windows = 5'd5;
        cyc(); cyc();
        fifoIn_axis_tready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            s_axis_tvalid = 1'b1;
            #1;
            n_checks++;
            if (is_last !== (b == 1)) begin n_fail++; $display("FAIL busy_start_is_last beat%0d: got %b required %b", b, is_last, (b == 1)); end
            n_checks++;
            if (weight_array !== 4'h6) begin n_fail++; $display("FAIL busy_start_weights: got %h required 6", weight_array); end
            cyc();
        end
        s_axis_tvalid = 1'b0; fifoIn_axis_tready = 1'b0;
        fifoOut_axim_tvalid = 1'b1; fifoOut_axim_tready = 1'b1;
        cyc(); cyc();
        fifoOut_axim_tvalid = 1'b0; fifoOut_axim_tready = 1'b0;
        start = 1'b0; cfg_weights = 4'h0; cfg_num_windows = 5'd0;
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (done === 1'b1) nd++;
            cyc();
        end
        n_checks++;
        if (nd !== 1 || out_count !== 5'd2) begin
            n_fail++; $display("FAIL busy_start_done: done=%0d out_count=%0d required 1 2", nd, out_count);
        end
    endtask

    task automatic test_out_saturate();
        do_start(4'h7, 5'd1);
        cyc(); cyc();
        fifoOut_axim_tvalid = 1'b1; fifoOut_axim_tready = 1'b1;
        for (int i = 0; i < 35; i++) cyc();
        #1;
        n_checks++;
        if (out_count !== 5'd31 || busy !== 1'b1) begin
            n_fail++; $display("FAIL sat_out_count: got %0d busy=%b required 31 1", out_count, busy);
        end
        fifoOut_axim_tvalid = 1'b0; fifoOut_axim_tready = 1'b0;
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL sat_abort: busy=%b required 0", busy); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_toggle_ready();
        test_timeout();
        test_zero_windows();
        test_abort_and_reset();
        test_start_while_busy();
        test_out_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
